periferico_fifo: RTL and testbench

Receive-side buffer between the CPU send/ack bus and the peripheral's data consumer. It completes the four-phase send/ack handshake with the CPU, stores each received 4-bit word in a small FIFO, and presents the words in order on a valid/ready port to the downstream logic. Words are absorbed while the consumer stalls. Handshakes stall only when the FIFO is full.

---
 rtl/periferico_pkg.sv | 15 +
 rtl/periferico_fifo_if.sv | 36 +++
 rtl/periferico_fifo_mem.sv | 70 +++++++
 rtl/periferico_fifo.sv | 85 ++++++++
 tb/tb_periferico_fifo.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/periferico_pkg.sv
// Shared definitions for the periferico receive FIFO.
//   FifoWidth  : default data word width
//   StatsWidth : width of the optional stalled-handshake counter
//   hs_state_e : CPU send/ack handshake states
package periferico_pkg;

  localparam int unsigned FifoWidth  = 4;
  localparam int unsigned StatsWidth = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StAck  = 1'b1
  } hs_state_e;

endpackage

// File: rtl/periferico_fifo_if.sv
// Bus bundle for periferico_fifo.
//   in_send / in_dados / out_ack        : CPU four-phase send/ack bus
//   out_valid / out_dados / out_ready   : downstream valid/ready consumer port
// Modports: slave = FIFO side, master = driver/consumer side.
interface periferico_fifo_if
  import periferico_pkg::*;
#(
  parameter int unsigned WIDTH = FifoWidth
) ();

  logic             in_send;
  logic [WIDTH-1:0] in_dados;
  logic             out_ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_dados;
  logic             out_ready;

  modport slave (
    input  in_send,
    input  in_dados,
    input  out_ready,
    output out_ack,
    output out_valid,
    output out_dados
  );

  modport master (
    output in_send,
    output in_dados,
    output out_ready,
    input  out_ack,
    input  out_valid,
    input  out_dados
  );

endinterface

// File: rtl/periferico_fifo_mem.sv
// Storage, pointers and occupancy count for the periferico receive FIFO.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wr_en_i, wr_data_i    : push request (ignored when full)
//   rd_en_i, rd_data_o    : pop request (ignored when empty), fall-through head word
//   count_o, full_o, empty_o : occupancy
// Memory contents are not reset; only pointers and count are.
module periferico_fifo_mem
  import periferico_pkg::*;
#(
  parameter int unsigned Width = FifoWidth,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_en_i & ~full_o;
  assign rd_ok   = rd_en_i & ~empty_o;

  // Depth is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/periferico_fifo.sv
// Receive-side buffer: completes the CPU send/ack handshake, queues each word
// and presents it first-word-fall-through on a valid/ready port.
//   fifo_clock, fifo_reset : clock, synchronous active-high reset
//   bus (slave)            : in_send/in_dados/out_ack and out_valid/out_dados/out_ready
//   fifo_count             : number of stored words
//   fifo_drop_cycles       : only with PERIFERICO_FIFO_STATS_EN; saturating count of
//                            cycles a send waited in IDLE because the FIFO was full
module periferico_fifo
  import periferico_pkg::*;
#(
  parameter int unsigned WIDTH = FifoWidth,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    fifo_clock,
  input  logic                    fifo_reset,
  periferico_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef PERIFERICO_FIFO_STATS_EN
  ,
  output logic [StatsWidth-1:0]   fifo_drop_cycles
`endif
);

  hs_state_e state_q, state_d;
  logic      wr_en;
  logic      full, empty;

  periferico_fifo_mem #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i     (fifo_clock),
    .rst_i     (fifo_reset),
    .wr_en_i   (wr_en),
    .wr_data_i (bus.in_dados),
    .rd_en_i   (bus.out_ready),
    .rd_data_o (bus.out_dados),
    .count_o   (fifo_count),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_ff @(posedge fifo_clock) begin
    if (fifo_reset) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Full is judged on the current count only; a same-cycle read does not free a slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_send && !full) state_d = StAck;
      StAck:   if (!bus.in_send)         state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Exactly one write per handshake: only the IDLE->ACK edge writes.
  always_comb begin
    wr_en       = (state_q == StIdle) && bus.in_send && !full;
    bus.out_ack = (state_q == StAck);
  end

  assign bus.out_valid = ~empty;

`ifdef PERIFERICO_FIFO_STATS_EN
  logic [StatsWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                  stalled;

  assign stalled = (state_q == StIdle) && bus.in_send && full;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (stalled && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + StatsWidth'(1);
  end

  always_ff @(posedge fifo_clock) begin
    if (fifo_reset) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign fifo_drop_cycles = drop_cnt_q;
`endif

endmodule

// File: tb/tb_periferico_fifo.sv
module tb_periferico_fifo;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic             fifo_clock = 1'b0;
  logic             fifo_reset;
  logic [$clog2(D):0] fifo_count;
`ifdef PERIFERICO_FIFO_STATS_EN
  logic [7:0]       fifo_drop_cycles;
`endif

  periferico_fifo_if #(.WIDTH(W)) bus ();

  periferico_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .fifo_clock       (fifo_clock),
    .fifo_reset       (fifo_reset),
    .bus              (bus),
    .fifo_count       (fifo_count)
`ifdef PERIFERICO_FIFO_STATS_EN
    ,
    .fifo_drop_cycles (fifo_drop_cycles)
`endif
  );

  always #5 fifo_clock = ~fifo_clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word queue, ack flag, stall counter.
  logic [W-1:0] m_q[$];
  bit           m_ack;
  int           m_drops;
  logic [W-1:0] got[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit full, take, wr, stall;
    if (fifo_reset) begin
      m_q.delete();
      m_ack   = 0;
      m_drops = 0;
    end else begin
      full  = (m_q.size() == D);
      take  = bus.out_ready && (m_q.size() != 0);
      wr    = !m_ack && bus.in_send && !full;
      stall = !m_ack && bus.in_send && full;
      if (take) void'(m_q.pop_front());
      if (wr) m_q.push_back(bus.in_dados);
      if (wr) m_ack = 1;
      else if (m_ack && !bus.in_send) m_ack = 0;
      if (stall && m_drops < 255) m_drops++;
    end
  endtask

  task automatic compare();
    check_eq("ack", {31'd0, bus.out_ack}, {31'd0, m_ack});
    check_eq("valid", {31'd0, bus.out_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
    check_eq("count", 32'(fifo_count), 32'(m_q.size()));
    if (m_q.size() != 0) check_eq("dados", 32'(bus.out_dados), 32'(m_q[0]));
`ifdef PERIFERICO_FIFO_STATS_EN
    check_eq("drops", 32'(fifo_drop_cycles), 32'(m_drops));
`endif
  endtask

  // Inputs are held across the edge; the model sees the same values the DUT sampled.
  task automatic tick();
    @(posedge fifo_clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    fifo_reset = 1'b1;
    tick();
    tick();
    fifo_reset = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int n;
    bus.in_dados = d;
    bus.in_send  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_ack && n < 20);
    if (!bus.out_ack) check_eq("ack_timeout", 32'd0, 32'd1);
    bus.in_send = 1'b0;
    tick();
  endtask

  initial begin
    logic [W-1:0] exp_order[4];
    bus.in_send   = 1'b0;
    bus.in_dados  = '0;
    bus.out_ready = 1'b0;
    fifo_reset    = 1'b1;

    // Reset, then idle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_count", 32'(fifo_count), 32'd0);
    end

    // Single handshake, send held three cycles.
    bus.in_dados = 4'h5;
    bus.in_send  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("single_ack_high", {31'd0, bus.out_ack}, 32'd1);
    end
    bus.in_send = 1'b0;
    tick();
    check_eq("single_ack_low", {31'd0, bus.out_ack}, 32'd0);
    check_eq("single_count", 32'(fifo_count), 32'd1);
    check_eq("single_dados", 32'(bus.out_dados), 32'h5);

    // Fill, then a fifth send stalls.
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(W'(i));
    bus.in_dados = 4'h6;
    bus.in_send  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("fill_count", 32'(fifo_count), 32'd4);
    check_eq("fill_no_ack", {31'd0, bus.out_ack}, 32'd0);
`ifdef PERIFERICO_FIFO_STATS_EN
    check_eq("fill_drops", 32'(fifo_drop_cycles), 32'd3);
`endif

    // Drain one while full: the stalled word is accepted one cycle later.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("drain_ack_late", {31'd0, bus.out_ack}, 32'd0);
    check_eq("drain_count", 32'(fifo_count), 32'd3);
    tick();
    check_eq("drain_ack", {31'd0, bus.out_ack}, 32'd1);
    check_eq("drain_count_full", 32'(fifo_count), 32'd4);
    bus.in_send = 1'b0;
    tick();
    exp_order[0] = 4'h2;
    exp_order[1] = 4'h3;
    exp_order[2] = 4'h4;
    exp_order[3] = 4'h6;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_order", 32'(bus.out_dados), 32'(exp_order[i]));
      tick();
    end
    bus.out_ready = 1'b0;

    // Wrap: stream ten words with the consumer always ready.
    do_reset();
    got.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_dados = W'(i);
      bus.in_send  = 1'b1;
      if (bus.out_valid) got.push_back(bus.out_dados);
      tick();
      check_eq("wrap_count_le1", (fifo_count <= 1) ? 32'd1 : 32'd0, 32'd1);
      bus.in_send = 1'b0;
      if (bus.out_valid) got.push_back(bus.out_dados);
      tick();
      check_eq("wrap_count_le1", (fifo_count <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
    check_eq("wrap_total", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++) check_eq("wrap_order", 32'(got[i]), 32'(i));
    bus.out_ready = 1'b0;

    // Reset while in ACK with two stored words.
    do_reset();
    send_word(4'ha);
    bus.in_dados = 4'hb;
    bus.in_send  = 1'b1;
    tick();
    check_eq("pre_rst_count", 32'(fifo_count), 32'd2);
    fifo_reset = 1'b1;
    tick();
    check_eq("rst_ack", {31'd0, bus.out_ack}, 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    fifo_reset  = 1'b0;
    bus.in_send = 1'b0;
    tick();

    // Randomized traffic with bursty consumer and rare resets.
    for (int c = 0; c < 3000; c++) begin
      int bias;
      bias = ((c / 200) % 3 == 0) ? 10 : (((c / 200) % 3 == 1) ? 50 : 90);
      fifo_reset    = ($urandom_range(0, 299) == 0);
      bus.out_ready = ($urandom_range(0, 99) < bias);
      bus.in_dados  = W'($urandom);
      if (!bus.in_send) bus.in_send = ($urandom_range(0, 1) == 1);
      else if (bus.out_ack) bus.in_send = ($urandom_range(0, 9) < 3);
      else bus.in_send = ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
